// File: rtl/seq_int_div.sv
// Sequential radix-2 restoring integer divider (signed/unsigned) with stb/ack handshakes.
// Optional macro SEQ_INT_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC/POST.
module seq_int_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_signed,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic [WIDTH-1:0] output_z,
    output logic [WIDTH-1:0] output_r,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, POST, OUT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             signed_q;
    logic             a_ack_q, b_ack_q;
    logic [WIDTH-1:0] quo_q, rem_q, div_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q, r_neg_q, dz_q, ovf_q;
    logic [WIDTH-1:0] z_q, r_q;
    logic             stb_q;
`ifdef SEQ_INT_DIV_EARLY_OUT_EN
    logic             dwell_q;
    logic [WIDTH-1:0] early_z_d, early_r_d;
`endif

    logic             a_take, b_take;
    logic             a_neg_d, b_neg_d;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic             dz_d, ovf_d;
    logic [WIDTH:0]   shifted_d;
    logic             fits_d;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH-1:0] z_fin_d, r_fin_d;

    always_comb begin
        a_take  = (state_q == IDLE) && a_ack_q && input_a_stb;
        b_take  = (state_q == IDLE) && b_ack_q && input_b_stb;

        a_neg_d = signed_q && a_q[WIDTH-1];
        b_neg_d = signed_q && b_q[WIDTH-1];
        mag_a_d = a_neg_d ? (~a_q + 1'b1) : a_q;
        mag_b_d = b_neg_d ? (~b_q + 1'b1) : b_q;
        dz_d    = (b_q == '0);
        ovf_d   = signed_q && (a_q == MIN_NEG) && (b_q == '1);

        // Shift in the next dividend bit and keep the difference only if the divisor fits.
        shifted_d = {rem_q, quo_q[WIDTH-1]};
        fits_d    = (shifted_d >= {1'b0, div_q});
        rem_d     = fits_d ? (shifted_d[WIDTH-1:0] - div_q) : shifted_d[WIDTH-1:0];
        quo_d     = {quo_q[WIDTH-2:0], fits_d};

        z_fin_d = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        r_fin_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        if (dz_q) begin
            z_fin_d = '1;
            r_fin_d = a_q;
        end else if (ovf_q) begin
            z_fin_d = a_q;
            r_fin_d = '0;
        end

`ifdef SEQ_INT_DIV_EARLY_OUT_EN
        early_z_d = dz_d ? '1 : a_q;
        early_r_d = dz_d ? a_q : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            a_ack_q  <= 1'b1;
            b_ack_q  <= 1'b1;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            z_q      <= '0;
            r_q      <= '0;
            stb_q    <= 1'b0;
`ifdef SEQ_INT_DIV_EARLY_OUT_EN
            dwell_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_take) begin
                        a_q     <= input_a;
                        a_ack_q <= 1'b0;
                    end
                    if (b_take) begin
                        b_q      <= input_b;
                        signed_q <= input_signed;
                        b_ack_q  <= 1'b0;
                    end
                    // Leave on the edge that completes the operand pair.
                    if ((!a_ack_q || a_take) && (!b_ack_q || b_take))
                        state_q <= PREP;
                end
                PREP: begin
                    quo_q   <= mag_a_d;
                    div_q   <= mag_b_d;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    q_neg_q <= a_neg_d ^ b_neg_d;
                    r_neg_q <= a_neg_d;
                    dz_q    <= dz_d;
                    ovf_q   <= ovf_d;
`ifdef SEQ_INT_DIV_EARLY_OUT_EN
                    // Special cases dwell one extra PREP cycle so results land two cycles after capture.
                    if (dz_d || ovf_d) begin
                        if (dwell_q) begin
                            dwell_q <= 1'b0;
                            z_q     <= early_z_d;
                            r_q     <= early_r_d;
                            stb_q   <= 1'b1;
                            state_q <= OUT;
                        end else begin
                            dwell_q <= 1'b1;
                        end
                    end else begin
                        state_q <= CALC;
                    end
`else
                    state_q <= CALC;
`endif
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER)
                        state_q <= POST;
                end
                POST: begin
                    z_q     <= z_fin_d;
                    r_q     <= r_fin_d;
                    stb_q   <= 1'b1;
                    state_q <= OUT;
                end
                OUT: begin
                    if (output_z_ack) begin
                        stb_q   <= 1'b0;
                        a_ack_q <= 1'b1;
                        b_ack_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Acks are forced low while reset is asserted.
    assign input_a_ack  = a_ack_q && rst_n;
    assign input_b_ack  = b_ack_q && rst_n;
    assign output_z     = z_q;
    assign output_r     = r_q;
    assign output_z_stb = stb_q;

endmodule

// File: tb/tb_seq_int_div.sv
// Directed, table-driven bench for seq_int_div at WIDTH=32 plus handshake and reset sequences.
module tb_seq_int_div;

  localparam int W        = 32;
  localparam int NORM_LAT = W + 2;
`ifdef SEQ_INT_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = W + 2;
`endif
  localparam int TIMEOUT  = 200;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] input_a = '0;
  logic         input_a_stb = 1'b0;
  logic         input_a_ack;
  logic [W-1:0] input_b = '0;
  logic         input_signed = 1'b0;
  logic         input_b_stb = 1'b0;
  logic         input_b_ack;
  logic [W-1:0] output_z;
  logic [W-1:0] output_r;
  logic         output_z_stb;
  logic         output_z_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int a_xfers = 0;
  int z_xfers = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] z;
    logic [W-1:0] r;
    logic         special;
  } vec_t;

  vec_t vecs[12];

  seq_int_div #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_signed (input_signed),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_r     (output_r),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (input_a_stb && input_a_ack) a_xfers++;
    if (output_z_stb && output_z_ack) z_xfers++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for output_z_stb after a capture edge; returns cycles counted.
  task automatic wait_result(output int lat, input int drop_ack_at);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == drop_ack_at) output_z_ack = 1'b0;
    end while (!output_z_stb && lat < TIMEOUT);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [W-1:0] ez, input logic [W-1:0] er,
                        input int elat);
    int lat;
    @(negedge clk);
    chk({tag, "_acks_ready"}, 64'({input_a_ack, input_b_ack}), 64'(2'b11));
    input_a = a;
    input_b = b;
    input_signed = sgn;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    input_a = $urandom;
    input_b = $urandom;
    input_signed = ~sgn;
    wait_result(lat, -1);
    chk({tag, "_latency"}, 64'(lat), 64'(elat));
    chk({tag, "_z"}, 64'(output_z), 64'(ez));
    chk({tag, "_r"}, 64'(output_r), 64'(er));
    chk({tag, "_acks_busy"}, 64'({input_a_ack, input_b_ack}), 64'(2'b00));
    @(negedge clk);
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    chk({tag, "_stb_cleared"}, 64'(output_z_stb), 64'(1'b0));
    chk({tag, "_acks_back"}, 64'({input_a_ack, input_b_ack}), 64'(2'b11));
  endtask

  initial begin
    int lat;
    int a_base;
    int z_base;

    vecs[0]  = '{a: 32'd20,         b: 32'd3,          sgn: 1'b0, z: 32'd6,          r: 32'd2,          special: 1'b0};
    vecs[1]  = '{a: 32'hFFFFFFF9,   b: 32'd2,          sgn: 1'b1, z: 32'hFFFFFFFD,   r: 32'hFFFFFFFF,   special: 1'b0};
    vecs[2]  = '{a: 32'hFFFFFFFF,   b: 32'd1,          sgn: 1'b0, z: 32'hFFFFFFFF,   r: 32'd0,          special: 1'b0};
    vecs[3]  = '{a: 32'h12345678,   b: 32'd0,          sgn: 1'b0, z: 32'hFFFFFFFF,   r: 32'h12345678,   special: 1'b1};
    vecs[4]  = '{a: 32'h12345678,   b: 32'd0,          sgn: 1'b1, z: 32'hFFFFFFFF,   r: 32'h12345678,   special: 1'b1};
    vecs[5]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   sgn: 1'b1, z: 32'h80000000,   r: 32'd0,          special: 1'b1};
    vecs[6]  = '{a: 32'd100,        b: 32'd7,          sgn: 1'b0, z: 32'd14,         r: 32'd2,          special: 1'b0};
    vecs[7]  = '{a: 32'd7,          b: 32'hFFFFFFFE,   sgn: 1'b1, z: 32'hFFFFFFFD,   r: 32'd1,          special: 1'b0};
    vecs[8]  = '{a: 32'hFFFFFF9C,   b: 32'd7,          sgn: 1'b1, z: 32'hFFFFFFF2,   r: 32'hFFFFFFFE,   special: 1'b0};
    vecs[9]  = '{a: 32'h80000000,   b: 32'hFFFFFFFF,   sgn: 1'b0, z: 32'd0,          r: 32'h80000000,   special: 1'b0};
    vecs[10] = '{a: 32'd3,          b: 32'd5,          sgn: 1'b0, z: 32'd0,          r: 32'd3,          special: 1'b0};
    vecs[11] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   sgn: 1'b1, z: 32'd1,          r: 32'd0,          special: 1'b0};

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_acks_low", 64'({input_a_ack, input_b_ack}), 64'(2'b00));
    chk("rst_stb", 64'(output_z_stb), 64'(1'b0));
    chk("rst_z", 64'(output_z), 64'(0));
    chk("rst_r", 64'(output_r), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_acks_high", 64'({input_a_ack, input_b_ack}), 64'(2'b11));

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].z, vecs[i].r,
             vecs[i].special ? SPEC_LAT : NORM_LAT);
    end

    // staggered operands, output_z_ack early and then held low
    a_base = a_xfers;
    z_base = z_xfers;
    @(negedge clk);
    input_a = 32'd1000;
    input_signed = 1'b0;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a = 32'hDEADBEEF;
    chk("stag_a_ack_drop", 64'(input_a_ack), 64'(1'b0));
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("stag_a_ack_low", 64'({input_a_ack, input_b_ack}), 64'(2'b01));
    end
    @(negedge clk);
    input_a_stb = 1'b0;
    input_b = 32'd9;
    input_b_stb = 1'b1;
    @(posedge clk);
    #1;
    input_b_stb = 1'b0;
    input_b = 32'd1;
    output_z_ack = 1'b1;
    wait_result(lat, 3);
    chk("stag_latency", 64'(lat), 64'(NORM_LAT));
    chk("stag_a_once", 64'(a_xfers - a_base), 64'(1));
    for (int k = 0; k < 10; k++) begin
      chk("stag_hold_stb", 64'(output_z_stb), 64'(1'b1));
      chk("stag_hold_z", 64'(output_z), 64'(111));
      chk("stag_hold_r", 64'(output_r), 64'(1));
      @(posedge clk);
      #1;
    end
    chk("stag_hold_acks", 64'({input_a_ack, input_b_ack}), 64'(2'b00));
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    chk("stag_single_xfer", 64'(z_xfers - z_base), 64'(1));
    chk("stag_stb_low", 64'(output_z_stb), 64'(1'b0));
    chk("stag_acks_back", 64'({input_a_ack, input_b_ack}), 64'(2'b11));

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    input_a = 32'd50000;
    input_b = 32'd3;
    input_signed = 1'b0;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_z", 64'(output_z), 64'(0));
    chk("midrst_r", 64'(output_r), 64'(0));
    chk("midrst_stb", 64'(output_z_stb), 64'(1'b0));
    chk("midrst_acks", 64'({input_a_ack, input_b_ack}), 64'(2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_acks_high", 64'({input_a_ack, input_b_ack}), 64'(2'b11));
    run_op("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, NORM_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_int_div.md
SEQ_INT_DIV -- requirements
Module: seq_int_div

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 input_a  input  WIDTH  dividend.
REQ-005 input_a_stb  input  1  dividend valid.
REQ-006 input_a_ack  output  1  dividend accepted; transfer on input_a_stb & input_a_ack at clock edge.
REQ-007 input_b  input  WIDTH  divisor.
REQ-008 input_signed  input  1  1 = two's-complement operation; sampled with input_b.
REQ-009 input_b_stb  input  1  divisor valid.
REQ-010 input_b_ack  output  1  divisor accepted; transfer on input_b_stb & input_b_ack at clock edge.
REQ-011 output_z  output  WIDTH  quotient.
REQ-012 output_r  output  WIDTH  remainder.
REQ-013 output_z_stb  output  1  results valid.
REQ-014 output_z_ack  input  1  consumer took results; transfer on output_z_stb & output_z_ack at clock edge.

Function
REQ-015 States: IDLE, PREP, CALC, POST, OUT.
REQ-016 IDLE: input_a_ack high while dividend not yet held; input_b_ack high while divisor not yet held; each operand captured independently, same-cycle capture of both allowed.
REQ-017 Captured operand's ack drops the cycle after capture and stays low until OUT completes.
REQ-018 Both operands held -> PREP on the next edge: take magnitudes if input_signed, record quotient/remainder signs, detect divide-by-zero and signed overflow.
REQ-019 CALC: radix-2 restoring division, one quotient bit per cycle, exactly WIDTH cycles, iteration counter $clog2(WIDTH)+1 bits.
REQ-020 POST: negate quotient if operand signs differ (signed mode); remainder takes dividend sign; then OUT.
REQ-021 OUT: output_z_stb high; output_z/output_r stable until handshake; handshake edge -> IDLE, stb low, both operand acks high again next cycle.
REQ-022 Latency: output_z_stb high WIDTH+2 cycles after the edge capturing the last operand (34 for WIDTH=32); throughput one operation per WIDTH+4 cycles minimum.
REQ-023 Divide by zero: output_z all ones, output_r = dividend, both modes.
REQ-024 Signed overflow (dividend = most-negative, divisor = -1): output_z = dividend, output_r = 0.
REQ-025 output_z_ack low: state held in OUT indefinitely, no operand accepted.
REQ-026 input_*_stb during PREP/CALC/POST/OUT ignored (acks low); operand values sampled only at capture.
REQ-027 output_z_ack asserted outside OUT has no effect.

Reset
REQ-028 rst_n low forces IDLE asynchronously, in any state including mid-CALC; partial result discarded.
REQ-029 Reset values: output_z = 0, output_r = 0, output_z_stb = 0, input_a_ack = 1, input_b_ack = 1 once rst_n is high (both low while rst_n low).
REQ-030 First capture possible on the first rising edge with rst_n high.

Configuration
REQ-031 Macro SEQ_INT_DIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow go PREP -> OUT directly, output_z_stb high 2 cycles after last capture.
REQ-032 Macro undefined: special cases traverse CALC and POST, same latency as REQ-022, results per REQ-023/024.

Verification
REQ-033 WIDTH=32, unsigned, a=20, b=3 -> output_z=6, output_r=2, stb exactly 34 cycles after capture.
REQ-034 Signed, a=0xFFFFFFF9 (-7), b=2 -> output_z=0xFFFFFFFD, output_r=0xFFFFFFFF; unsigned 0xFFFFFFFF/1 -> 0xFFFFFFFF r 0.
REQ-035 a=0x12345678, b=0, both modes -> output_z=0xFFFFFFFF, output_r=0x12345678; latency 2 with macro, 34 without.
REQ-036 Signed a=0x80000000, b=0xFFFFFFFF -> output_z=0x80000000, output_r=0.
REQ-037 input_a_stb 5 cycles before input_b_stb, output_z_ack held low 10 cycles -> a acked once, outputs stable all 10 cycles, single transfer, acks high next cycle.
REQ-038 rst_n pulsed low at CALC iteration 10 -> outputs zero immediately, new 100/7 after release gives 14 r 2.
